// File: rtl/uart_tx_engine_if.sv
// Valid/ready word handshake into the UART transmitter.
// The producer side uses the master modport and the transmitter uses the slave modport.
interface uart_tx_engine_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmitter: start, DATA_W data bits LSB first, optional parity, 1-2 stop bits.
// The baud timer, bit counter and shift register all sit behind a single frame FSM.
module uart_tx_engine #(
  parameter int DATA_W     = 8,
  parameter int BAUD_DIV   = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_engine_if.slave   bus,
  output logic              tx,
  output logic              busy,
  output logic              done
);
  localparam int BW = $clog2(BAUD_DIV);
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  if (DATA_W < 5 || DATA_W > 9 || BAUD_DIV < 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_EN < 0 || PARITY_EN > 1 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_err
    $error("uart_tx_engine: illegal parameter combination");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     baud_q, baud_d;
  logic [CW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              bit_end;

  assign bit_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    if (state_q != S_IDLE) baud_d = bit_end ? '0 : baud_q + 1'b1;
    case (state_q)
      S_IDLE: if (bus.tx_valid) begin
        state_d = S_START;
        baud_d  = '0;
        bit_d   = '0;
        shift_d = bus.tx_data;
        par_d   = (^bus.tx_data) ^ (PARITY_ODD != 0);
      end
      S_START: if (bit_end) begin
        state_d = S_DATA;
        bit_d   = '0;
      end
      S_DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        if (bit_q == DATA_LAST) begin
          bit_d   = '0;
          state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      S_PARITY: if (bit_end) begin
        state_d = S_STOP;
        bit_d   = '0;
      end
      S_STOP: if (bit_end) begin
        if (bit_q == STOP_LAST) begin
          state_d = S_IDLE;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // tx is registered from the state being entered so it lines up with the state flop
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign tx           = tx_q;
  assign bus.tx_ready = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_STOP) && bit_end && (bit_q == STOP_LAST);
endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: four configurations (8N1, 8E1, 8O1, 5N2) at BAUD_DIV=4 share one
// stimulus; a frame-vector model predicts tx/busy/ready/done on every cycle.
module tb_uart_tx_engine;
  localparam int BD = 4;

  function automatic int dw(input int i); return (i == 3) ? 5 : 8; endfunction
  function automatic int pe(input int i); return (i == 1 || i == 2) ? 1 : 0; endfunction
  function automatic int po(input int i); return (i == 2) ? 1 : 0; endfunction
  function automatic int sb(input int i); return (i == 3) ? 2 : 1; endfunction
  function automatic int nlen(input int i); return (1 + dw(i) + pe(i) + sb(i)) * BD; endfunction

  // Bit k of the returned vector is serial bit k of the frame (bit 0 = start)
  function automatic logic [15:0] frame_of(input int i, input logic [8:0] w);
    logic [15:0] f;
    logic        p;
    f    = '1;
    f[0] = 1'b0;
    p    = 1'b0;
    for (int j = 0; j < dw(i); j++) begin
      f[1+j] = w[j];
      p      = p ^ w[j];
    end
    if (pe(i) != 0) f[1+dw(i)] = p ^ (po(i) != 0);
    return f;
  endfunction

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] data [4];
  logic [3:0] valid;
  logic [3:0] tx_w, busy_w, done_w, ready_w;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx_engine_if #(.DATA_W(dw(g))) bus ();
    assign bus.tx_data  = data[g][dw(g)-1:0];
    assign bus.tx_valid = valid[g];
    assign ready_w[g]   = bus.tx_ready;
    uart_tx_engine #(
      .DATA_W(dw(g)), .BAUD_DIV(BD), .PARITY_EN(pe(g)), .PARITY_ODD(po(g)), .STOP_BITS(sb(g))
    ) u_dut (
      .clk(clk), .reset(reset), .bus(bus), .tx(tx_w[g]), .busy(busy_w[g]), .done(done_w[g])
    );
  end

  // Model: a frame is active for nlen cycles after an accept; el = cycles since the accept edge
  logic        act [4];
  int          el [4];
  logic [15:0] fr [4];
  int          acc_cnt [4];

  always @(posedge clk or negedge reset) begin
    for (int i = 0; i < 4; i++) begin
      if (!reset) begin
        act[i]     <= 1'b0;
        el[i]      <= 0;
        acc_cnt[i] <= 0;
      end else if (!act[i]) begin
        if (valid[i]) begin
          act[i]     <= 1'b1;
          el[i]      <= 0;
          fr[i]      <= frame_of(i, data[i]);
          acc_cnt[i] <= acc_cnt[i] + 1;
        end
      end else if (el[i] == nlen(i) - 1) begin
        act[i] <= 1'b0;
      end else begin
        el[i] <= el[i] + 1;
      end
    end
  end

  int           n_checks = 0;
  int           n_err = 0;
  int           base [4];
  logic [127:0] h_tx [4];
  logic [127:0] h_busy [4];
  logic [127:0] h_done [4];
  logic [127:0] h_ready [4];

  task automatic check(input string nm, input int i, input logic [15:0] a, input logic [15:0] e);
    n_checks++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s u%0d @%0t: got %0h expected %0h", nm, i, $time, a, e);
    end
  endtask

  task automatic compare_all();
    logic etx, edone;
    for (int i = 0; i < 4; i++) begin
      etx   = act[i] ? fr[i][el[i]/BD] : 1'b1;
      edone = act[i] && (el[i] == nlen(i) - 1);
      check("tx",    i, 16'(tx_w[i]),    16'(etx));
      check("busy",  i, 16'(busy_w[i]),  16'(act[i]));
      check("ready", i, 16'(ready_w[i]), 16'(!act[i]));
      check("done",  i, 16'(done_w[i]),  16'(edone));
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_all();
  endtask

  // mode 1: hold valid until the second accept; mode 2: toggle data and pulse valid mid-frame
  task automatic capture(input int n, input int mode);
    for (int i = 0; i < 4; i++) begin
      h_tx[i] = '0; h_busy[i] = '0; h_done[i] = '0; h_ready[i] = '0;
    end
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < 4; i++) begin
        h_tx[i][c]    = tx_w[i];
        h_busy[i][c]  = busy_w[i];
        h_done[i][c]  = done_w[i];
        h_ready[i][c] = ready_w[i];
        if (mode == 1 && acc_cnt[i] >= base[i] + 2) valid[i] = 1'b0;
        if (mode == 2) begin
          data[i]  = 9'(c * 37 + i);
          valid[i] = (c == 5 || c == 9 || c == 13 || c == 20 || c == 27);
        end
      end
      step();
    end
  endtask

  // Called at a negedge with all engines idle; index c = 0 is the half cycle after the accept edge
  task automatic send(input logic [8:0] w, input int n, input int mode);
    for (int i = 0; i < 4; i++) begin
      data[i]  = w;
      valid[i] = 1'b1;
      base[i]  = acc_cnt[i];
    end
    step();
    for (int i = 0; i < 4; i++) begin
      if (mode == 1) data[i] = 9'h0AA;
      else valid[i] = 1'b0;
    end
    capture(n, mode);
  endtask

  function automatic int first_done(input int i);
    for (int c = 0; c < 128; c++) if (h_done[i][c]) return c;
    return -1;
  endfunction

  initial begin
    logic [9:0] bits;
    valid = '0;
    for (int i = 0; i < 4; i++) data[i] = '0;
    #2 reset = 1'b0;
    step();
    check("rst_tx", 0, 16'(tx_w[0]), 16'd1);
    check("rst_busy", 0, 16'(busy_w[0]), 16'd0);
    check("rst_ready", 0, 16'(ready_w[0]), 16'd1);
    check("rst_done", 0, 16'(done_w[0]), 16'd0);
    step();
    reset = 1'b1;
    step();

    // 8N1 0xA5
    send(9'h0A5, 56, 0);
    for (int k = 0; k < 10; k++) bits[k] = h_tx[0][4*k+2];
    check("a5_bits", 0, 16'(bits), 16'b11_0100_1010);
    check("a5_done_at", 0, 16'(first_done(0)), 16'd39);
    check("a5_ready39", 0, 16'(h_ready[0][39]), 16'd0);
    check("a5_ready40", 0, 16'(h_ready[0][40]), 16'd1);

    // 0x07: even parity 1, odd parity 0, 44-cycle frames
    send(9'h007, 56, 0);
    check("e_parity", 1, 16'(h_tx[1][38]), 16'd1);
    check("o_parity", 2, 16'(h_tx[2][38]), 16'd0);
    check("e_len", 1, 16'($countones(h_busy[1])), 16'd44);

    // 5N2 0x1F: 32-cycle frame
    send(9'h01F, 56, 0);
    check("n2_len", 3, 16'($countones(h_busy[3])), 16'd32);
    check("n2_busy31", 3, 16'(h_busy[3][31]), 16'd1);
    check("n2_busy32", 3, 16'(h_busy[3][32]), 16'd0);
    check("n2_start", 3, 16'(h_tx[3][2]), 16'd0);
    check("n2_done_at", 3, 16'(first_done(3)), 16'd31);

    // Back-to-back 0x55 then 0xAA with tx_valid held
    send(9'h055, 100, 1);
    check("b2b_gap_tx", 0, 16'(h_tx[0][40]), 16'd1);
    check("b2b_gap_busy", 0, 16'(h_busy[0][40]), 16'd0);
    check("b2b_gap_ready", 0, 16'(h_ready[0][40]), 16'd1);
    check("b2b_start2", 0, 16'(h_tx[0][41]), 16'd0);
    check("b2b_ready41", 0, 16'(h_ready[0][41]), 16'd0);
    check("b2b_aa_b0", 0, 16'(h_tx[0][47]), 16'd0);
    check("b2b_aa_b1", 0, 16'(h_tx[0][51]), 16'd1);
    check("b2b_dones", 0, 16'($countones(h_done[0])), 16'd2);
    for (int i = 0; i < 4; i++) valid[i] = 1'b0;
    step();

    // Reset during data bit 3 of 0xFF
    send(9'h0FF, 17, 0);
    #1 reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("mid_rst_tx", i, 16'(tx_w[i]), 16'd1);
      check("mid_rst_busy", i, 16'(busy_w[i]), 16'd0);
      check("mid_rst_ready", i, 16'(ready_w[i]), 16'd1);
    end
    step();
    step();
    reset = 1'b1;
    step();
    send(9'h000, 56, 0);
    check("z_bit8", 0, 16'(h_tx[0][34]), 16'd0);
    check("z_stop", 0, 16'(h_tx[0][38]), 16'd1);
    check("z_epar", 1, 16'(h_tx[1][38]), 16'd0);
    check("z_opar", 2, 16'(h_tx[2][38]), 16'd1);

    // Mid-frame tx_data churn and tx_valid pulses must not add frames
    send(9'h03C, 56, 2);
    for (int i = 0; i < 4; i++) check("churn_dones", i, 16'($countones(h_done[i])), 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
